// File: rtl/alarm_bank.sv
// alarm_bank: multi-slot alarm with ring/snooze/dismiss control.
// Stored hh:mm slots are compared against the 24h BCD clock each second.
module alarm_bank #(
  parameter int NUM_ALARMS = 4,
  parameter int ID_W       = 2,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sec_tick,
  input  logic [19:0]           hh_mm_ss,
  input  logic                  set_alarm,
  input  logic [ID_W-1:0]       alarm_id,
  input  logic [19:0]           stime_alarm,
  input  logic                  alarm_en_in,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic                  ringing,
  output logic [ID_W-1:0]       ring_id,
  output logic [NUM_ALARMS-1:0] alarm_en,
  output logic [1:0]            snooze_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ring_id_q, ring_id_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [7:0]      secs_q, secs_d;
  logic [12:0]     base_q, base_d;
  logic [12:0]     wake_q, wake_d;

  logic [12:0]     slot_hm [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en_q;

  logic [12:0]     cur_hm;
  logic [12:0]     w_hm;
  logic            sec0;
  logic            tick0;
  logic            time_ok;
  logic            wr_ok;
  logic            kill;
  logic            hit;
  logic [ID_W-1:0] win;
  logic            unused_sec;

  assign cur_hm     = hh_mm_ss[19:7];
  assign sec0       = (hh_mm_ss[6:0] == 7'd0);
  assign tick0      = sec_tick && sec0;
  assign w_hm       = stime_alarm[19:7];
  assign unused_sec = ^stime_alarm[6:0];

  assign time_ok = (w_hm[10:7] <= 4'd9) &&
                   (w_hm[3:0] <= 4'd9) &&
                   (w_hm[6:4] <= 3'd5) &&
                   ((w_hm[12:11] < 2'd2) ||
                    ((w_hm[12:11] == 2'd2) &&
                     (w_hm[10:7] <= 4'd3)));

  assign wr_ok = set_alarm && time_ok &&
                 (int'(alarm_id) < NUM_ALARMS);

  // Disabling the slot that owns the current event ends it.
  assign kill = wr_ok && !alarm_en_in &&
                (alarm_id == ring_id_q) &&
                (state_q != IDLE);

  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (en_q[i] && (slot_hm[i] == cur_hm)) begin
        hit = 1'b1;
        win = ID_W'(i);
      end
    end
  end

  function automatic logic [12:0] add_min(
    input logic [12:0] t,
    input logic [1:0]  n
  );
    int hrs;
    int mins;
    hrs  = int'(t[12:11]) * 10 + int'(t[10:7]);
    mins = hrs * 60 + int'(t[6:4]) * 10 + int'(t[3:0]);
    mins = (mins + SNOOZE_MIN * int'(n)) % 1440;
    hrs  = mins / 60;
    mins = mins % 60;
    return {2'(hrs / 10), 4'(hrs % 10),
            3'(mins / 10), 4'(mins % 10)};
  endfunction

  always_comb begin
    state_d   = state_q;
    ring_id_d = ring_id_q;
    cnt_d     = cnt_q;
    secs_d    = secs_q;
    base_d    = base_q;
    wake_d    = wake_q;
    unique case (state_q)
      IDLE: begin
        if (tick0 && hit) begin
          state_d   = RING;
          ring_id_d = win;
          cnt_d     = 2'd0;
          secs_d    = 8'd0;
          base_d    = cur_hm;
        end
      end
      RING: begin
        if (kill || dismiss) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else if (snooze) begin
          if (int'(cnt_q) < MAX_SNOOZE) begin
            state_d = SNOOZE;
            cnt_d   = cnt_q + 2'd1;
            wake_d  = add_min(base_q, cnt_d);
          end else begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end
        end else if (sec_tick) begin
          secs_d = secs_q + 8'd1;
          if (secs_d == 8'(RING_SECS)) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end
        end
      end
      SNOOZE: begin
        if (kill || dismiss) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else if (tick0 && (cur_hm == wake_q)) begin
          state_d = RING;
          secs_d  = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ring_id_q <= '0;
      cnt_q     <= 2'd0;
      secs_q    <= 8'd0;
      base_q    <= 13'd0;
      wake_q    <= 13'd0;
    end else begin
      state_q   <= state_d;
      ring_id_q <= ring_id_d;
      cnt_q     <= cnt_d;
      secs_q    <= secs_d;
      base_q    <= base_d;
      wake_q    <= wake_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_hm[i] <= 13'd0;
      end
    end else if (wr_ok) begin
      slot_hm[alarm_id] <= w_hm;
      en_q[alarm_id]    <= alarm_en_in;
    end
  end

  assign ringing    = (state_q == RING);
  assign ring_id    = ring_id_q;
  assign alarm_en   = en_q;
  assign snooze_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: directed plus random stimulus for alarm_bank,
// checked against a minutes-of-day reference model.
module tb_alarm_bank;
  localparam int N  = 4;
  localparam int RS = 60;
  localparam int SM = 5;
  localparam int MS = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sec_tick = 1'b0;
  logic set_alarm = 1'b0;
  logic alarm_en_in = 1'b0;
  logic snooze = 1'b0;
  logic dismiss = 1'b0;
  logic [1:0] alarm_id = 2'd0;
  logic [19:0] hh_mm_ss = 20'd0;
  logic [19:0] stime_alarm = 20'd0;
  logic ringing;
  logic [1:0] ring_id;
  logic [3:0] alarm_en;
  logic [1:0] snooze_cnt;

  int errors = 0;
  int checks = 0;
  int now = 0;
  int w_ht, w_hu, w_mt, w_mu;

  int m_min [N];
  bit m_en [N];
  int m_mode, m_id, m_cnt, m_secs, m_base, m_wake;

  always #5 clk = ~clk;

  alarm_bank #(
    .NUM_ALARMS(N), .ID_W(2), .RING_SECS(RS),
    .SNOOZE_MIN(SM), .MAX_SNOOZE(MS)
  ) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick),
    .hh_mm_ss(hh_mm_ss), .set_alarm(set_alarm),
    .alarm_id(alarm_id), .stime_alarm(stime_alarm),
    .alarm_en_in(alarm_en_in), .snooze(snooze),
    .dismiss(dismiss), .ringing(ringing),
    .ring_id(ring_id), .alarm_en(alarm_en),
    .snooze_cnt(snooze_cnt)
  );

  function automatic logic [19:0] bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {2'(h / 10), 4'(h % 10), 3'(m / 10),
            4'(m % 10), 3'(x / 10), 4'(x % 10)};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_min[i] = 0;
      m_en[i]  = 0;
    end
    m_mode = 0; m_id = 0; m_cnt = 0;
    m_secs = 0; m_base = 0; m_wake = 0;
  endtask

  task automatic model_step();
    int cur, w;
    bit sec0, ok, kill, hit;
    cur  = now / 60;
    sec0 = (now % 60) == 0;
    ok   = set_alarm && w_hu <= 9 && w_mu <= 9 &&
           w_mt <= 5 && (w_ht * 10 + w_hu) <= 23;
    kill = ok && !alarm_en_in &&
           int'(alarm_id) == m_id && m_mode != 0;
    hit = 0;
    w   = 0;
    if (sec_tick && sec0)
      for (int i = 0; i < N; i++)
        if (!hit && m_en[i] && m_min[i] == cur) begin
          hit = 1;
          w   = i;
        end
    case (m_mode)
      0: if (hit) begin
        m_mode = 1; m_id = w; m_cnt = 0;
        m_secs = 0; m_base = cur;
      end
      1: if (kill || dismiss) begin
        m_mode = 0; m_cnt = 0;
      end else if (snooze) begin
        if (m_cnt < MS) begin
          m_cnt++;
          m_wake = (m_base + SM * m_cnt) % 1440;
          m_mode = 2;
        end else begin
          m_mode = 0; m_cnt = 0;
        end
      end else if (sec_tick) begin
        m_secs++;
        if (m_secs == RS) begin
          m_mode = 0; m_cnt = 0;
        end
      end
      default: if (kill || dismiss) begin
        m_mode = 0; m_cnt = 0;
      end else if (sec_tick && sec0 && cur == m_wake) begin
        m_mode = 1; m_secs = 0;
      end
    endcase
    if (ok) begin
      m_min[alarm_id] = (w_ht * 10 + w_hu) * 60 +
                        w_mt * 10 + w_mu;
      m_en[alarm_id]  = alarm_en_in;
    end
  endtask

  task automatic compare_all();
    logic [3:0] ev;
    for (int i = 0; i < N; i++) ev[i] = m_en[i];
    chk("ringing", ringing, m_mode == 1);
    chk("ring_id", ring_id, m_id);
    chk("alarm_en", alarm_en, ev);
    chk("snooze_cnt", snooze_cnt, m_cnt);
  endtask

  task automatic cyc(input bit tk = 0,
                     input bit sz = 0,
                     input bit ds = 0);
    sec_tick = tk;
    snooze   = sz;
    dismiss  = ds;
    hh_mm_ss = bcd(now);
    model_step();
    @(posedge clk);
    #1;
    sec_tick  = 0;
    snooze    = 0;
    dismiss   = 0;
    set_alarm = 0;
    compare_all();
  endtask

  task automatic tick();
    now = (now + 1) % 86400;
    cyc(1);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    now = h * 3600 + m * 60 + s;
    cyc();
  endtask

  task automatic set_wr(input int id, input int ht, input int hu,
                        input int mt, input int mu, input bit en);
    w_ht = ht; w_hu = hu; w_mt = mt; w_mu = mu;
    stime_alarm = {2'(ht), 4'(hu), 3'(mt), 4'(mu),
                   7'($urandom)};
    alarm_id    = 2'(id);
    alarm_en_in = en;
    set_alarm   = 1;
  endtask

  task automatic wrt(input int id, input int h,
                     input int m, input bit en);
    set_wr(id, h / 10, h % 10, m / 10, m % 10, en);
    cyc();
  endtask

  initial begin
    bit tk, sz, ds;
    int mm;
    model_reset();
    w_ht = 0; w_hu = 0; w_mt = 0; w_mu = 0;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1;

    wrt(1, 7, 30, 1);
    set_time(7, 29, 59);
    tick();
    chk("ring_on", ringing, 1);
    chk("ring_id1", ring_id, 1);
    for (int i = 0; i < RS - 1; i++) tick();
    chk("ring_hold", ringing, 1);
    tick();
    chk("ring_timeout", ringing, 0);

    wrt(1, 7, 30, 0);
    wrt(0, 6, 0, 1);
    wrt(2, 6, 0, 1);
    set_time(5, 59, 59);
    tick();
    chk("prio_id", ring_id, 0);
    cyc(0, 0, 1);
    chk("dismissed", ringing, 0);
    repeat (3) tick();
    chk("slot2_dropped", ringing, 0);

    wrt(0, 6, 0, 0);
    wrt(2, 6, 0, 0);
    wrt(3, 23, 58, 1);
    set_time(23, 57, 59);
    tick();
    chk("ring3", ringing, 1);
    cyc(0, 1);
    chk("snz1", snooze_cnt, 1);
    set_time(0, 2, 59);
    chk("snz_wait", ringing, 0);
    tick();
    chk("wake_0003", ringing, 1);
    cyc(0, 1);
    set_time(0, 7, 59);
    tick();
    chk("wake_0008", ringing, 1);
    chk("snz2", snooze_cnt, 2);
    cyc(0, 1);
    set_time(0, 12, 59);
    tick();
    chk("wake_0013", ringing, 1);
    chk("snz3", snooze_cnt, 3);
    cyc(0, 1);
    chk("snz4_idle", ringing, 0);
    chk("snz4_cnt", snooze_cnt, 0);

    wrt(0, 24, 10, 1);
    chk("bad_hour", alarm_en, 4'b1000);
    set_wr(0, 1, 2, 6, 5, 1);
    cyc();
    chk("bad_min", alarm_en, 4'b1000);
    set_time(23, 57, 59);
    tick();
    cyc(0, 1, 1);
    chk("both_idle", ringing, 0);
    chk("both_cnt", snooze_cnt, 0);

    wrt(1, 8, 0, 1);
    set_time(7, 59, 59);
    tick();
    chk("ring1b", ringing, 1);
    wrt(1, 8, 0, 0);
    chk("kill_ring", ringing, 0);
    chk("kill_en", alarm_en[1], 0);

    set_time(23, 57, 59);
    tick();
    chk("pre_rst", ringing, 1);
    rst = 0;
    #2;
    chk("arst_ring", ringing, 0);
    chk("arst_en", alarm_en, 0);
    chk("arst_id", ring_id, 0);
    model_reset();
    @(negedge clk);
    rst = 1;
    set_time(23, 59, 59);
    tick();
    chk("no_0000", ringing, 0);

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0)
          set_wr($urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 15), $urandom_range(0, 7),
                 $urandom_range(0, 15), 1'($urandom));
        else begin
          mm = 600 + $urandom_range(0, 20);
          set_wr($urandom_range(0, 3), mm / 600,
                 (mm / 60) % 10, (mm % 60) / 10, mm % 10,
                 $urandom_range(0, 3) != 0);
        end
      end
      tk = $urandom_range(0, 2) == 0;
      if (tk)
        now = (600 + $urandom_range(0, 22)) * 60 +
              (($urandom_range(0, 3) == 0) ?
               $urandom_range(1, 59) : 0);
      sz = $urandom_range(0, 15) == 0;
      ds = $urandom_range(0, 23) == 0;
      cyc(tk, sz, ds);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Parametrised multi-alarm unit: the successor to the single set_alarm/stime_alarm path of the clock.
- Holds NUM_ALARMS independent alarms, each with its own enable.
- Compares them against the running 24h BCD time once per second and drives a ring/snooze/dismiss state machine.
- Sits beside time_view, consuming its 24h hh_mm_ss and 1 Hz strobe; 12h display conversion stays in time_view.

Parameters:
- NUM_ALARMS, 4, number of alarm slots (1..16)
- ID_W, 2, width of alarm index; must equal clog2(NUM_ALARMS), minimum 1
- RING_SECS, 60, sec_tick count after which an unanswered ring auto-dismisses (1..255)
- SNOOZE_MIN, 5, minutes added per snooze (1..59)
- MAX_SNOOZE, 3, snoozes allowed per ring event (0..3)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- sec_tick  in  1  one-cycle 1 Hz strobe from time_view
- hh_mm_ss  in  20  current 24h time {2 h-tens, 4 h-units, 3 m-tens, 4 m-units, 3 s-tens, 4 s-units}, BCD
- set_alarm  in  1  one-cycle write strobe
- alarm_id  in  ID_W  slot addressed by set_alarm
- stime_alarm  in  20  alarm time, same packing; seconds field ignored
- alarm_en_in  in  1  enable written with set_alarm
- snooze  in  1  one-cycle snooze request
- dismiss  in  1  one-cycle dismiss request
- ringing  out  1  high while in RING
- ring_id  out  ID_W  slot that is ringing or snoozed
- alarm_en  out  NUM_ALARMS  per-slot enable bits
- snooze_cnt  out  2  snoozes taken in the current event

Behaviour:
- Reset, asynchronous on rst low:
  - state=IDLE, ringing=0, ring_id=0, alarm_en=0, snooze_cnt=0.
  - All stored hh:mm = 00:00; ring counter and wake time cleared.
- Write (any state):
  - set_alarm stores stime_alarm[19:7] and alarm_en_in into slot alarm_id at the next edge.
  - The write is ignored entirely if the time is invalid: hours>23, m-tens>5, h-units>9 or m-units>9.
  - alarm_id >= NUM_ALARMS is ignored.
- Match:
  - Evaluated only in a cycle with sec_tick=1 and seconds field==00.
  - Slot i matches when alarm_en[i]=1 and stored hh:mm equals hh_mm_ss hh:mm.
  - Several matches in one tick: the lowest index wins; the others are dropped.
- IDLE -> RING on a match:
  - ringing=1 from the edge after the matching tick (latency 1 cycle).
  - ring_id = winner, snooze_cnt=0, ring counter=0.
  - Current hh:mm is latched as base time.
- RING:
  - Counter increments on each sec_tick; matches from other slots are ignored.
  - dismiss -> IDLE, ringing=0, snooze_cnt=0.
  - Counter reaching RING_SECS -> IDLE, same as dismiss.
  - snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE, ringing=0, snooze_cnt+1.
    - Wake = base + SNOOZE_MIN*snooze_cnt(new) minutes.
    - BCD add: minute carry into hours; 23:5x + carry wraps to 00.
  - snooze with snooze_cnt==MAX_SNOOZE is treated as dismiss.
  - dismiss and snooze in the same cycle: dismiss wins.
- SNOOZE:
  - sec_tick with seconds==00 and hh:mm==wake -> RING with the same ring_id and base; ring counter cleared, snooze_cnt kept.
  - dismiss -> IDLE, snooze_cnt=0. snooze is ignored.
  - Other slots still cannot trigger; their matches are dropped.
- Writes to the active slot:
  - New time or enable=1: stored value updates, the active event continues.
  - alarm_en_in=0 for slot ring_id while in RING or SNOOZE: -> IDLE next edge, ringing=0, snooze_cnt=0.
- ring_id holds its last value in IDLE.
- No combinational input-to-output paths.

Test Plan:
- Reset mid-RING: drop rst low asynchronously -> ringing=0, alarm_en=0, state IDLE with no clock edge required; stored slot times read back as 00:00 (no match at 00:00 until rewritten).
- Write slot 1 = 07:30, enabled; drive 07:29:59 then tick to 07:30:00 -> ringing=1 one cycle after the tick, ring_id=1. After 60 further ticks with no input -> ringing=0.
- Slots 0 and 2 both 06:00 enabled -> ring_id=0. Dismiss -> IDLE; slot 2 does not ring.
- Slot 3 = 23:58, SNOOZE_MIN=5: snooze -> snooze_cnt=1; ring resumes at 00:03:00. Snooze -> 00:08 (cnt=2), snooze -> 00:13 (cnt=3). Fourth snooze -> IDLE, snooze_cnt=0.
- Write 24:10 or 12:65 to slot 0 -> no change in alarm_en or stored time. Same-cycle snooze+dismiss during RING -> IDLE.
- While slot 1 is ringing, write slot 1 with alarm_en_in=0 -> ringing=0 next edge, alarm_en[1]=0.
